// File: rtl/vga_coord_pkg.sv
// Shared constants for the VGA coordinate tracker: default 640x480@60 timing,
// counter widths, sync polarity encoding and an elaboration range helper.
package vga_coord_pkg;

  localparam int H_W_DEF      = 11;
  localparam int V_W_DEF      = 11;

  localparam int H_BACK_DEF   = 48;
  localparam int H_ACTIVE_DEF = 640;
  localparam int V_BACK_DEF   = 33;
  localparam int V_ACTIVE_DEF = 480;

  localparam bit SYNC_POL_LOW  = 1'b0;
  localparam bit SYNC_POL_HIGH = 1'b1;

  // The all-ones code is the saturation marker, so the window must end below it.
  function automatic bit span_fits(input int span, input int width);
    return span < ((2 ** width) - 1);
  endfunction

endpackage : vga_coord_pkg

// File: rtl/vga_sync_edge.sv
// Sync polarity normalisation plus a one-cycle history register, giving the
// asserted sense and the first-deasserted-sample strobe of one sync input.
module vga_sync_edge
  import vga_coord_pkg::*;
#(
  parameter bit SYNC_POL = SYNC_POL_LOW
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sync_i,
  output logic as_o,
  output logic fall_o
);

  logic as_q;

  assign as_o   = (sync_i == SYNC_POL);
  assign fall_o = as_q & ~as_o;

  // NOTE: registers are written with <= so every flop samples the pre-edge
  // value; blocking assignments here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      as_q <= 1'b0;
    end else begin
      as_q <= as_o;
    end
  end

endmodule : vga_sync_edge

// File: rtl/vga_sync_coord_tracker.sv
// Recovers active-window pixel coordinates from a running HSYNC/VSYNC pair.
// Optional build macro VGA_COORD_SYNC_LOST_EN adds a registered sync_lost flag.
module vga_sync_coord_tracker
  import vga_coord_pkg::*;
#(
  parameter int H_W      = H_W_DEF,
  parameter int V_W      = V_W_DEF,
  parameter int H_BACK   = H_BACK_DEF,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_BACK   = V_BACK_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter bit SYNC_POL = SYNC_POL_LOW
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           HSYNC_Sig,
  input  logic           VSYNC_Sig,
  output logic [H_W-1:0] x_sig,
  output logic [V_W-1:0] y_sig,
  output logic           active,
  output logic           line_start,
  output logic           frame_start,
  output logic           sync_lost
);

  if (!span_fits(H_BACK + H_ACTIVE, H_W)) begin : g_h_span_err
    $error("vga_sync_coord_tracker: H_BACK+H_ACTIVE does not fit below 2**H_W-1");
  end
  if (!span_fits(V_BACK + V_ACTIVE, V_W)) begin : g_v_span_err
    $error("vga_sync_coord_tracker: V_BACK+V_ACTIVE does not fit below 2**V_W-1");
  end

  localparam logic [H_W-1:0] H_MAX   = '1;
  localparam logic [V_W-1:0] V_MAX   = '1;
  localparam logic [H_W-1:0] H_START = H_W'(H_BACK);
  localparam logic [H_W-1:0] H_STOP  = H_W'(H_BACK + H_ACTIVE);
  localparam logic [V_W-1:0] V_START = V_W'(V_BACK);
  localparam logic [V_W-1:0] V_STOP  = V_W'(V_BACK + V_ACTIVE);

  logic           hs_as;
  logic           hs_fall;
  logic           vs_as;
  logic [H_W-1:0] h_cnt_q, h_cnt_d;
  logic [V_W-1:0] v_cnt_q, v_cnt_d;
  logic           act_h, act_v;

  vga_sync_edge #(
    .SYNC_POL (SYNC_POL)
  ) u_hs_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .sync_i (HSYNC_Sig),
    .as_o   (hs_as),
    .fall_o (hs_fall)
  );

  // Vertical timing only needs the level, never an edge.
  assign vs_as = (VSYNC_Sig == SYNC_POL);

  always_comb begin
    // NOTE: the hold value is assigned first so every path drives h_cnt_d;
    // a missing default branch would infer a latch.
    h_cnt_d = h_cnt_q;
    if (hs_as) begin
      h_cnt_d = '0;
    end else if (h_cnt_q != H_MAX) begin
      h_cnt_d = h_cnt_q + H_W'(1);
    end
  end

  // Vsync wins over a coincident hsync fall so the frame restarts cleanly.
  always_comb begin
    v_cnt_d = v_cnt_q;
    if (vs_as) begin
      v_cnt_d = '0;
    end else if (hs_fall && (v_cnt_q != V_MAX)) begin
      v_cnt_d = v_cnt_q + V_W'(1);
    end
  end

  // NOTE: counters reset to all-ones (saturated), not zero, so the window
  // stays closed until a real vsync and hsync have been seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q <= H_MAX;
      v_cnt_q <= V_MAX;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign act_h  = (h_cnt_q >= H_START) && (h_cnt_q < H_STOP);
  assign act_v  = (v_cnt_q >= V_START) && (v_cnt_q < V_STOP);
  assign active = act_h && act_v;

  assign x_sig       = active ? (h_cnt_q - H_START) : '0;
  assign y_sig       = active ? (v_cnt_q - V_START) : '0;
  assign line_start  = active && (h_cnt_q == H_START);
  assign frame_start = line_start && (v_cnt_q == V_START);

`ifdef VGA_COORD_SYNC_LOST_EN
  logic sync_lost_q, sync_lost_d;
  logic h_hit, v_hit;

  // Set on the edge a counter first saturates, so a sync that clears the flag
  // is not immediately overridden by a counter that was already parked.
  assign h_hit = (h_cnt_d == H_MAX) && (h_cnt_q != H_MAX);
  assign v_hit = (v_cnt_d == V_MAX) && (v_cnt_q != V_MAX);

  always_comb begin
    sync_lost_d = sync_lost_q;
    if (hs_as || vs_as) begin
      sync_lost_d = 1'b0;
    end else if (h_hit || v_hit) begin
      sync_lost_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_lost_q <= 1'b1;
    end else begin
      sync_lost_q <= sync_lost_d;
    end
  end

  assign sync_lost = sync_lost_q;
`else
  assign sync_lost = 1'b0;
`endif

endmodule : vga_sync_coord_tracker

// File: tb/tb_vga_sync_coord_tracker.sv
// Self-checking bench: an active-low and an active-high instance share one
// asserted-sense stimulus stream and are compared against an event model.
module tb_vga_sync_coord_tracker;

  localparam int HW   = 4;
  localparam int VW   = 4;
  localparam int HB   = 2;
  localparam int HA   = 4;
  localparam int VB   = 1;
  localparam int VA   = 2;
  localparam int HMAX = 15;
  localparam int VMAX = 15;
`ifdef VGA_COORD_SYNC_LOST_EN
  localparam bit SL_EN = 1'b1;
`else
  localparam bit SL_EN = 1'b0;
`endif

  typedef struct packed { logic hs; logic vs; } smp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          hs0 = 1'b1, vs0 = 1'b1, hs1 = 1'b0, vs1 = 1'b0;
  logic [HW-1:0] x0, x1;
  logic [VW-1:0] y0, y1;
  logic          a0, a1, ls0, ls1, fs0, fs1, sl0, sl1;
  logic [10:0]   obs0, obs1;

  int checks = 0;
  int failures = 0;

  // Event model: edges since reset, last asserted hsync/vsync edges, and the
  // hsync falls seen since the last vsync.
  int   edge_n;
  int   last_hs;
  int   last_vs;
  bit   prev_hs;
  int   fall_edges[$];
  smp_t sched[$];

  always #5 clk = ~clk;

  vga_sync_coord_tracker #(
    .H_W(HW), .V_W(VW), .H_BACK(HB), .H_ACTIVE(HA),
    .V_BACK(VB), .V_ACTIVE(VA), .SYNC_POL(1'b0)
  ) u_dut_low (
    .clk(clk), .rst_n(rst_n), .HSYNC_Sig(hs0), .VSYNC_Sig(vs0),
    .x_sig(x0), .y_sig(y0), .active(a0), .line_start(ls0),
    .frame_start(fs0), .sync_lost(sl0)
  );

  vga_sync_coord_tracker #(
    .H_W(HW), .V_W(VW), .H_BACK(HB), .H_ACTIVE(HA),
    .V_BACK(VB), .V_ACTIVE(VA), .SYNC_POL(1'b1)
  ) u_dut_high (
    .clk(clk), .rst_n(rst_n), .HSYNC_Sig(hs1), .VSYNC_Sig(vs1),
    .x_sig(x1), .y_sig(y1), .active(a1), .line_start(ls1),
    .frame_start(fs1), .sync_lost(sl1)
  );

  assign obs0 = {a0, ls0, fs0, x0, y0};
  assign obs1 = {a1, ls1, fs1, x1, y1};

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    edge_n  = 0;
    last_hs = -1;
    last_vs = -1;
    prev_hs = 1'b0;
    fall_edges.delete();
  endtask

  task automatic model_edge(input bit hs, input bit vs);
    edge_n++;
    if (vs) begin
      last_vs = edge_n;
      fall_edges.delete();
    end else if (prev_hs && !hs) begin
      fall_edges.push_back(edge_n);
    end
    if (hs) last_hs = edge_n;
    prev_hs = hs;
  endtask

  function automatic logic [10:0] expected();
    int       h, v;
    bit       act;
    logic [3:0] x, y;
    if (last_hs < 0) h = HMAX;
    else h = ((edge_n - last_hs) > HMAX) ? HMAX : (edge_n - last_hs);
    if (last_vs < 0) v = VMAX;
    else v = (fall_edges.size() > VMAX) ? VMAX : fall_edges.size();
    act = (h >= HB) && (h < HB + HA) && (v >= VB) && (v < VB + VA);
    x = act ? 4'(h - HB) : 4'd0;
    y = act ? 4'(v - VB) : 4'd0;
    return {act, act && (h == HB), act && (h == HB) && (v == VB), x, y};
  endfunction

  task automatic drive_edge(input bit hs, input bit vs);
    hs0 = ~hs; vs0 = ~vs; hs1 = hs; vs1 = vs;
    @(posedge clk);
    model_edge(hs, vs);
    #1;
  endtask

  task automatic push_smp(input bit hs, input bit vs);
    smp_t s;
    s.hs = hs;
    s.vs = vs;
    sched.push_back(s);
  endtask

  task automatic push_line(input int hs_w, input int tail);
    repeat (hs_w) push_smp(1'b1, 1'b0);
    repeat (tail) push_smp(1'b0, 1'b0);
  endtask

  task automatic test_reset();
    logic [10:0] exp;
    #2;
    exp = expected();
    checks += 3;
    if (obs0 !== exp) begin failures++; $display("FAIL reset_out dut_low got=%h want=%h", obs0, exp); end
    if (obs1 !== exp) begin failures++; $display("FAIL reset_out dut_high got=%h want=%h", obs1, exp); end
    if (sl0 !== SL_EN) begin failures++; $display("FAIL reset_sync_lost got=%b want=%b", sl0, SL_EN); end
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_edge(1'b0, 1'b0);
      exp = expected();
      checks += 2;
      if (obs0 !== exp) begin failures++; $display("FAIL reset_idle dut_low i=%0d got=%h want=%h", i, obs0, exp); end
      if (obs1 !== exp) begin failures++; $display("FAIL reset_idle dut_high i=%0d got=%h want=%h", i, obs1, exp); end
    end
  endtask

  task automatic test_frame();
    logic [10:0] exp;
    int act_n[3] = '{0, 0, 0};
    int ls_n[3]  = '{0, 0, 0};
    int fs_n[3]  = '{0, 0, 0};
    int want_act[3] = '{4, 4, 0};
    int want_ls[3]  = '{1, 1, 0};
    int want_fs[3]  = '{1, 0, 0};
    int ln, j;
    sched.delete();
    repeat (3) push_smp(1'b0, 1'b1);
    repeat (3) push_line(2, 10);
    for (int i = 0; i < sched.size(); i++) begin
      drive_edge(sched[i].hs, sched[i].vs);
      exp = expected();
      checks += 2;
      if (obs0 !== exp) begin failures++; $display("FAIL frame dut_low i=%0d got=%h want=%h", i, obs0, exp); end
      if (obs1 !== exp) begin failures++; $display("FAIL frame dut_high i=%0d got=%h want=%h", i, obs1, exp); end
      if (i >= 3) begin
        ln = (i - 3) / 12;
        j  = (i - 3) % 12;
        act_n[ln] += int'(a0);
        ls_n[ln]  += int'(ls0);
        fs_n[ln]  += int'(fs0);
        if (ln == 0 && j >= 3 && j <= 7) begin
          checks++;
          if (j <= 6 ? (a0 !== 1'b1 || x0 !== 4'(j - 3) || y0 !== 4'd0) : (a0 !== 1'b0)) begin
            failures++;
            $display("FAIL line1_trace j=%0d got a=%b x=%0d y=%0d want x=%0d", j, a0, x0, y0, j - 3);
          end
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      checks += 3;
      if (act_n[k] != want_act[k]) begin failures++; $display("FAIL frame_active_count line=%0d got=%0d want=%0d", k + 1, act_n[k], want_act[k]); end
      if (ls_n[k] != want_ls[k]) begin failures++; $display("FAIL frame_line_start line=%0d got=%0d want=%0d", k + 1, ls_n[k], want_ls[k]); end
      if (fs_n[k] != want_fs[k]) begin failures++; $display("FAIL frame_frame_start line=%0d got=%0d want=%0d", k + 1, fs_n[k], want_fs[k]); end
    end
  endtask

  task automatic test_vs_collision();
    logic [10:0] exp;
    int act_after, act_line;
    act_after = 0;
    act_line  = 0;
    sched.delete();
    repeat (2) push_smp(1'b1, 1'b0);
    push_smp(1'b0, 1'b1);
    repeat (8) push_smp(1'b0, 1'b0);
    push_line(2, 8);
    for (int i = 0; i < sched.size(); i++) begin
      drive_edge(sched[i].hs, sched[i].vs);
      exp = expected();
      checks += 2;
      if (obs0 !== exp) begin failures++; $display("FAIL collision dut_low i=%0d got=%h want=%h", i, obs0, exp); end
      if (obs1 !== exp) begin failures++; $display("FAIL collision dut_high i=%0d got=%h want=%h", i, obs1, exp); end
      if (i >= 3 && i < 11) act_after += int'(a0);
      if (i >= 11) act_line += int'(a1);
    end
    checks += 2;
    if (act_after != 0) begin failures++; $display("FAIL collision_no_increment got=%0d want=0", act_after); end
    if (act_line != 4) begin failures++; $display("FAIL collision_next_line got=%0d want=4", act_line); end
  endtask

  task automatic test_reset_midline();
    logic [10:0] exp;
    int act_nov, act_v;
    act_nov = 0;
    act_v   = 0;
    sched.delete();
    push_smp(1'b0, 1'b1);
    push_line(2, 4);
    for (int i = 0; i < sched.size(); i++) begin
      drive_edge(sched[i].hs, sched[i].vs);
      exp = expected();
      checks += 2;
      if (obs0 !== exp) begin failures++; $display("FAIL midline dut_low i=%0d got=%h want=%h", i, obs0, exp); end
      if (obs1 !== exp) begin failures++; $display("FAIL midline dut_high i=%0d got=%h want=%h", i, obs1, exp); end
    end
    checks++;
    if (a0 !== 1'b1 || x0 !== 4'd2) begin failures++; $display("FAIL midline_pre_reset got a=%b x=%0d want a=1 x=2", a0, x0); end
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    checks += 3;
    if (obs0 !== 11'd0) begin failures++; $display("FAIL async_reset dut_low got=%h want=0", obs0); end
    if (obs1 !== 11'd0) begin failures++; $display("FAIL async_reset dut_high got=%h want=0", obs1); end
    if (sl1 !== SL_EN) begin failures++; $display("FAIL async_reset_sync_lost got=%b want=%b", sl1, SL_EN); end
    #1 rst_n = 1'b1;
    sched.delete();
    push_line(2, 10);
    push_smp(1'b0, 1'b1);
    push_line(2, 10);
    for (int i = 0; i < sched.size(); i++) begin
      drive_edge(sched[i].hs, sched[i].vs);
      exp = expected();
      checks += 2;
      if (obs0 !== exp) begin failures++; $display("FAIL post_reset dut_low i=%0d got=%h want=%h", i, obs0, exp); end
      if (obs1 !== exp) begin failures++; $display("FAIL post_reset dut_high i=%0d got=%h want=%h", i, obs1, exp); end
      if (i < 12) act_nov += int'(a0);
      else act_v += int'(a0);
    end
    checks += 2;
    if (act_nov != 0) begin failures++; $display("FAIL post_reset_no_vsync got=%0d want=0", act_nov); end
    if (act_v != 4) begin failures++; $display("FAIL post_reset_with_vsync got=%0d want=4", act_v); end
  endtask

  task automatic test_saturation();
    logic [10:0] exp;
    sched.delete();
    push_smp(1'b0, 1'b1);
    push_line(1, 20);
    for (int i = 0; i < sched.size(); i++) begin
      drive_edge(sched[i].hs, sched[i].vs);
      exp = expected();
      checks += 2;
      if (obs0 !== exp) begin failures++; $display("FAIL saturate dut_low i=%0d got=%h want=%h", i, obs0, exp); end
      if (obs1 !== exp) begin failures++; $display("FAIL saturate dut_high i=%0d got=%h want=%h", i, obs1, exp); end
    end
    checks += 3;
    if (a0 !== 1'b0) begin failures++; $display("FAIL saturate_inactive got=%b want=0", a0); end
    if (sl0 !== SL_EN) begin failures++; $display("FAIL saturate_sync_lost dut_low got=%b want=%b", sl0, SL_EN); end
    if (sl1 !== SL_EN) begin failures++; $display("FAIL saturate_sync_lost dut_high got=%b want=%b", sl1, SL_EN); end
    drive_edge(1'b1, 1'b0);
    checks += 2;
    if (sl0 !== 1'b0) begin failures++; $display("FAIL sync_lost_clear dut_low got=%b want=0", sl0); end
    if (sl1 !== 1'b0) begin failures++; $display("FAIL sync_lost_clear dut_high got=%b want=0", sl1); end
  endtask

  task automatic test_random();
    logic [10:0] exp;
    int nl;
    sched.delete();
    for (int f = 0; f < 6; f++) begin
      repeat ($urandom_range(1, 3)) push_smp(1'($urandom_range(0, 1)), 1'b1);
      nl = $urandom_range(2, 5);
      for (int l = 0; l < nl; l++) push_line($urandom_range(1, 3), $urandom_range(3, 14));
    end
    for (int i = 0; i < sched.size(); i++) begin
      if ($urandom_range(0, 39) == 0) sched[i].vs = 1'b1;
    end
    for (int i = 0; i < sched.size(); i++) begin
      drive_edge(sched[i].hs, sched[i].vs);
      exp = expected();
      checks += 2;
      if (obs0 !== exp) begin failures++; $display("FAIL random dut_low i=%0d got=%h want=%h", i, obs0, exp); end
      if (obs1 !== exp) begin failures++; $display("FAIL random dut_high i=%0d got=%h want=%h", i, obs1, exp); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_frame();
    test_vs_collision();
    test_reset_midline();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_vga_sync_coord_tracker
